// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution: latches the predicted branch or jalr leaving ID, recomputes the
// real outcome from the forwarded EX operands, and on a mispredict raises a one-cycle flush with rollback PC.
module branch_resolve_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             PL_stall,
    input  logic             B_type_id_i,
    input  logic [2:0]       func3_id_i,
    input  logic             jalr_id_i,
    input  logic             jalr_pred_en_id_i,
    input  logic [WIDTH-1:0] jalr_pred_target_id_i,
    input  logic             B_type_result_id_i,
    input  logic [WIDTH-1:0] pc_id_i,
    input  logic [WIDTH-1:0] imme_id_i,
    input  logic [WIDTH-1:0] Rs1_data_ex_i,
    input  logic [WIDTH-1:0] Rs2_data_ex_i,
    output logic             PL_flush,
    output logic [WIDTH-1:0] pc_rollback,
    output logic             B_type_branch_failed,
    output logic             beq_branch_failed,
    output logic             bne_branch_failed,
    output logic             blt_branch_failed,
    output logic             bge_branch_failed,
    output logic             bltu_branch_failed,
    output logic             bgeu_branch_failed,
    output logic [WIDTH-1:0] pc_branch_filled,
    output logic             B_type_result_branch_failed,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispredict_cnt
);

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [WIDTH-1:0] PC_STEP   = {{(WIDTH-3){1'b0}}, 3'd4};
    localparam logic [WIDTH-1:0] LSB_CLEAR = {{(WIDTH-1){1'b1}}, 1'b0};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_FLUSH = 1'b1
    } state_t;

    function automatic logic f3_defined(input logic [2:0] f3);
        logic ok;
        case (f3)
            F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU: ok = 1'b1;
            default:                                         ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic branch_taken(input logic [2:0] f3,
                                          input logic [WIDTH-1:0] a,
                                          input logic [WIDTH-1:0] b);
        logic tk;
        case (f3)
            F3_BEQ:  tk = (a == b);
            F3_BNE:  tk = (a != b);
            F3_BLT:  tk = ($signed(a) <  $signed(b));
            F3_BGE:  tk = ($signed(a) >= $signed(b));
            F3_BLTU: tk = (a <  b);
            F3_BGEU: tk = (a >= b);
            default: tk = 1'b0;
        endcase
        return tk;
    endfunction

    // One-hot order: beq, bne, blt, bge, bltu, bgeu (MSB first)
    function automatic logic [5:0] kind_onehot(input logic [2:0] f3);
        logic [5:0] oh;
        case (f3)
            F3_BEQ:  oh = 6'b100000;
            F3_BNE:  oh = 6'b010000;
            F3_BLT:  oh = 6'b001000;
            F3_BGE:  oh = 6'b000100;
            F3_BLTU: oh = 6'b000010;
            F3_BGEU: oh = 6'b000001;
            default: oh = 6'b000000;
        endcase
        return oh;
    endfunction

    state_t           r_state;
    logic             r_valid;
    logic             r_btype;
    logic [2:0]       r_func3;
    logic             r_jalr;
    logic             r_jalr_pred_en;
    logic [WIDTH-1:0] r_pred_target;
    logic             r_pred_taken;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_imme;

    logic             r_flush;
    logic [WIDTH-1:0] r_rollback;
    logic             r_b_failed;
    logic [5:0]       r_kind;
    logic [WIDTH-1:0] r_pc_failed;
    logic             r_result_failed;
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_mispredict_cnt;

    logic             w_resolve;
    logic             w_taken;
    logic             w_b_fail;
    logic             w_j_fail;
    logic [WIDTH-1:0] w_b_rollback;
    logic [WIDTH-1:0] w_j_rollback;

    // Resolve the instruction currently in EX against its prediction
    always_comb begin
        w_resolve    = 1'b0;
        w_taken      = 1'b0;
        w_b_fail     = 1'b0;
        w_j_fail     = 1'b0;
        w_b_rollback = r_pc + PC_STEP;
        w_j_rollback = (Rs1_data_ex_i + r_imme) & LSB_CLEAR;
        if ((r_state == S_IDLE) && !PL_stall && r_valid) begin
            w_resolve = 1'b1;
        end else begin
            w_resolve = 1'b0;
        end
        w_taken = branch_taken(r_func3, Rs1_data_ex_i, Rs2_data_ex_i);
        if (w_taken) begin
            w_b_rollback = r_pc + r_imme;
        end else begin
            w_b_rollback = r_pc + PC_STEP;
        end
        if (r_btype) begin
            w_b_fail = f3_defined(r_func3) && (w_taken != r_pred_taken);
        end else if (r_jalr) begin
            w_j_fail = r_jalr_pred_en && (r_pred_target != Rs1_data_ex_i);
        end else begin
            w_b_fail = 1'b0;
            w_j_fail = 1'b0;
        end
    end

    // EX pipeline register: bubble on flush, hold on stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid        <= 1'b0;
            r_btype        <= 1'b0;
            r_func3        <= 3'b000;
            r_jalr         <= 1'b0;
            r_jalr_pred_en <= 1'b0;
            r_pred_target  <= {WIDTH{1'b0}};
            r_pred_taken   <= 1'b0;
            r_pc           <= {WIDTH{1'b0}};
            r_imme         <= {WIDTH{1'b0}};
        end else if (r_flush) begin
            r_valid <= 1'b0;
        end else if (!PL_stall) begin
            r_valid        <= 1'b1;
            r_btype        <= B_type_id_i;
            r_func3        <= func3_id_i;
            r_jalr         <= jalr_id_i;
            r_jalr_pred_en <= jalr_pred_en_id_i;
            r_pred_target  <= jalr_pred_target_id_i;
            r_pred_taken   <= B_type_result_id_i;
            r_pc           <= pc_id_i;
            r_imme         <= imme_id_i;
        end
    end

    // Flush FSM with registered strobes, rollback fields and saturating counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= S_IDLE;
            r_flush          <= 1'b0;
            r_rollback       <= {WIDTH{1'b0}};
            r_b_failed       <= 1'b0;
            r_kind           <= 6'b000000;
            r_pc_failed      <= {WIDTH{1'b0}};
            r_result_failed  <= 1'b0;
            r_branch_cnt     <= {CNT_W{1'b0}};
            r_mispredict_cnt <= {CNT_W{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_resolve) begin
                        if (r_btype && (r_branch_cnt != CNT_MAX)) begin
                            r_branch_cnt <= r_branch_cnt + CNT_ONE;
                        end
                        if ((w_b_fail || w_j_fail) && (r_mispredict_cnt != CNT_MAX)) begin
                            r_mispredict_cnt <= r_mispredict_cnt + CNT_ONE;
                        end
                        if (w_b_fail) begin
                            r_state         <= S_FLUSH;
                            r_flush         <= 1'b1;
                            r_rollback      <= w_b_rollback;
                            r_b_failed      <= 1'b1;
                            r_kind          <= kind_onehot(r_func3);
                            r_pc_failed     <= r_pc;
                            r_result_failed <= w_taken;
                        end else if (w_j_fail) begin
                            r_state         <= S_FLUSH;
                            r_flush         <= 1'b1;
                            r_rollback      <= w_j_rollback;
                            r_b_failed      <= 1'b0;
                            r_result_failed <= 1'b0;
                        end
                    end
                end
                // The EX slot holds a wrong-path instruction; leave it unresolved
                S_FLUSH: begin
                    r_state         <= S_IDLE;
                    r_flush         <= 1'b0;
                    r_b_failed      <= 1'b0;
                    r_result_failed <= 1'b0;
                end
                default: begin
                    r_state         <= S_IDLE;
                    r_flush         <= 1'b0;
                    r_b_failed      <= 1'b0;
                    r_result_failed <= 1'b0;
                end
            endcase
        end
    end

    assign PL_flush                    = r_flush;
    assign pc_rollback                 = r_rollback;
    assign B_type_branch_failed        = r_b_failed;
    assign beq_branch_failed           = r_kind[5];
    assign bne_branch_failed           = r_kind[4];
    assign blt_branch_failed           = r_kind[3];
    assign bge_branch_failed           = r_kind[2];
    assign bltu_branch_failed          = r_kind[1];
    assign bgeu_branch_failed          = r_kind[0];
    assign pc_branch_filled            = r_pc_failed;
    assign B_type_result_branch_failed = r_result_failed;
    assign branch_cnt                  = r_branch_cnt;
    assign mispredict_cnt              = r_mispredict_cnt;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed scenarios plus randomized traffic against an
// instruction-level reference model; a second instance with 4-bit counters covers saturation.
module tb_branch_resolve_unit;

    typedef struct packed {
        logic        v;
        logic        bt;
        logic [2:0]  f3;
        logic        j;
        logic        pen;
        logic [31:0] tgt;
        logic        pred;
        logic [31:0] pc;
        logic [31:0] imm;
    } ins_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic stall = 1'b0;
    ins_t id;
    logic [31:0] rs1 = 32'd0;
    logic [31:0] rs2 = 32'd0;

    logic        flush, btf, res, f4, btf4, res4;
    logic [31:0] rollback, pcf, rb4, pcf4, bcnt, mcnt;
    logic [5:0]  oh, oh4;
    logic [3:0]  bcnt4, mcnt4;

    always #5 clk = ~clk;

    branch_resolve_unit dut (
        .clk(clk), .rst_n(rst_n), .PL_stall(stall),
        .B_type_id_i(id.bt), .func3_id_i(id.f3), .jalr_id_i(id.j),
        .jalr_pred_en_id_i(id.pen), .jalr_pred_target_id_i(id.tgt),
        .B_type_result_id_i(id.pred), .pc_id_i(id.pc), .imme_id_i(id.imm),
        .Rs1_data_ex_i(rs1), .Rs2_data_ex_i(rs2),
        .PL_flush(flush), .pc_rollback(rollback), .B_type_branch_failed(btf),
        .beq_branch_failed(oh[5]), .bne_branch_failed(oh[4]), .blt_branch_failed(oh[3]),
        .bge_branch_failed(oh[2]), .bltu_branch_failed(oh[1]), .bgeu_branch_failed(oh[0]),
        .pc_branch_filled(pcf), .B_type_result_branch_failed(res),
        .branch_cnt(bcnt), .mispredict_cnt(mcnt)
    );

    branch_resolve_unit #(.WIDTH(32), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .PL_stall(stall),
        .B_type_id_i(id.bt), .func3_id_i(id.f3), .jalr_id_i(id.j),
        .jalr_pred_en_id_i(id.pen), .jalr_pred_target_id_i(id.tgt),
        .B_type_result_id_i(id.pred), .pc_id_i(id.pc), .imme_id_i(id.imm),
        .Rs1_data_ex_i(rs1), .Rs2_data_ex_i(rs2),
        .PL_flush(f4), .pc_rollback(rb4), .B_type_branch_failed(btf4),
        .beq_branch_failed(oh4[5]), .bne_branch_failed(oh4[4]), .blt_branch_failed(oh4[3]),
        .bge_branch_failed(oh4[2]), .bltu_branch_failed(oh4[1]), .bgeu_branch_failed(oh4[0]),
        .pc_branch_filled(pcf4), .B_type_result_branch_failed(res4),
        .branch_cnt(bcnt4), .mispredict_cnt(mcnt4)
    );

    int n_checks = 0;
    int n_errors = 0;

    // reference model: instruction sitting in EX, flush-in-progress flag, expected outputs
    ins_t        m_ex;
    logic        m_in_flush, m_flush, m_btf, m_res;
    logic [31:0] m_rb, m_pcf;
    logic [5:0]  m_oh;
    int          m_bcnt, m_mcnt;

    function automatic ins_t mk_b(input logic [2:0] f3, input logic [31:0] pc,
                                  input logic [31:0] imm, input logic pred);
        ins_t x = '0;
        x.bt = 1'b1; x.f3 = f3; x.pc = pc; x.imm = imm; x.pred = pred;
        return x;
    endfunction

    function automatic ins_t mk_j(input logic [31:0] tgt, input logic [31:0] pc,
                                  input logic [31:0] imm, input logic pen);
        ins_t x = '0;
        x.j = 1'b1; x.tgt = tgt; x.pc = pc; x.imm = imm; x.pen = pen;
        return x;
    endfunction

    function automatic logic known(input logic [2:0] f3);
        return (f3 == 3'd0) || (f3 == 3'd1) || (f3 >= 3'd4);
    endfunction

    function automatic logic actual(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return $signed(a) < $signed(b);
            3'd5:    return $signed(a) >= $signed(b);
            3'd6:    return a < b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [5:0] kind(input logic [2:0] f3);
        case (f3)
            3'd0:    return 6'b100000;
            3'd1:    return 6'b010000;
            3'd4:    return 6'b001000;
            3'd5:    return 6'b000100;
            3'd6:    return 6'b000010;
            3'd7:    return 6'b000001;
            default: return 6'b000000;
        endcase
    endfunction

    function automatic int sat4(input int c);
        return (c > 15) ? 15 : c;
    endfunction

    task automatic model_reset();
        m_ex = '0; m_in_flush = 1'b0; m_flush = 1'b0; m_btf = 1'b0; m_res = 1'b0;
        m_rb = 32'd0; m_pcf = 32'd0; m_oh = 6'd0; m_bcnt = 0; m_mcnt = 0;
    endtask

    // one clock: evaluate the EX instruction with current operands, then advance model state
    task automatic step();
        logic resolve, tk, bf, jf, old_flush;
        resolve   = !m_in_flush && !stall && m_ex.v;
        tk        = actual(m_ex.f3, rs1, rs2);
        bf        = m_ex.bt && known(m_ex.f3) && (tk != m_ex.pred);
        jf        = !m_ex.bt && m_ex.j && m_ex.pen && (m_ex.tgt != rs1);
        old_flush = m_flush;
        @(posedge clk);
        if (m_in_flush) begin
            m_in_flush = 1'b0; m_flush = 1'b0; m_btf = 1'b0; m_res = 1'b0;
        end else if (resolve) begin
            if (m_ex.bt) m_bcnt++;
            if (bf || jf) begin
                m_mcnt++;
                m_in_flush = 1'b1;
                m_flush    = 1'b1;
                if (bf) begin
                    m_btf = 1'b1; m_res = tk; m_pcf = m_ex.pc; m_oh = kind(m_ex.f3);
                    m_rb  = tk ? m_ex.pc + m_ex.imm : m_ex.pc + 32'd4;
                end else begin
                    m_btf = 1'b0; m_res = 1'b0;
                    m_rb  = (rs1 + m_ex.imm) & 32'hFFFF_FFFE;
                end
            end
        end
        if (old_flush) m_ex.v = 1'b0;
        else if (!stall) begin m_ex = id; m_ex.v = 1'b1; end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; stall = 1'b0; id = '0; rs1 = 32'd0; rs2 = 32'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if ({flush, btf, res, oh} !== 9'd0) begin n_errors++; $display("FAIL reset_bits got %b exp 0", {flush, btf, res, oh}); end
        n_checks++; if (rollback !== 32'd0 || pcf !== 32'd0) begin n_errors++; $display("FAIL reset_pcs got %h/%h exp 0/0", rollback, pcf); end
        n_checks++; if (bcnt !== 32'd0 || mcnt !== 32'd0 || mcnt4 !== 4'd0) begin n_errors++; $display("FAIL reset_cnt got %0d/%0d/%0d exp 0", bcnt, mcnt, mcnt4); end
        rst_n = 1'b1;
    endtask

    task automatic test_beq();
        id = mk_b(3'd0, 32'h100, 32'h40, 1'b0);
        step();
        id = '0; rs1 = 32'd5; rs2 = 32'd5;
        step();
        n_checks++; if (flush !== 1'b1 || pc_rollback_ne(32'h140)) begin n_errors++; $display("FAIL beq_flush got %b %h exp 1 00000140", flush, rollback); end
        n_checks++; if (oh !== 6'b100000 || res !== 1'b1 || btf !== 1'b1) begin n_errors++; $display("FAIL beq_strobes got %b %b %b exp 100000 1 1", oh, res, btf); end
        n_checks++; if (pcf !== 32'h100) begin n_errors++; $display("FAIL beq_pcf got %h exp 00000100", pcf); end
        n_checks++; if (bcnt !== 32'd1 || mcnt !== 32'd1) begin n_errors++; $display("FAIL beq_cnt got %0d/%0d exp 1/1", bcnt, mcnt); end
        step();
        n_checks++; if (flush !== 1'b0 || btf !== 1'b0 || rollback !== 32'h140) begin n_errors++; $display("FAIL beq_pulse_end got %b %b %h exp 0 0 00000140", flush, btf, rollback); end
    endtask

    function automatic logic pc_rollback_ne(input logic [31:0] e);
        return rollback !== e;
    endfunction

    task automatic test_blt_bltu();
        id = mk_b(3'd4, 32'h200, 32'h10, 1'b1);
        step();
        id = '0; rs1 = 32'hFFFF_FFFF; rs2 = 32'd1;
        step();
        n_checks++; if (flush !== 1'b0 || bcnt !== 32'd2 || mcnt !== 32'd1) begin n_errors++; $display("FAIL blt got %b %0d/%0d exp 0 2/1", flush, bcnt, mcnt); end
        id = mk_b(3'd6, 32'h200, 32'h10, 1'b1);
        step();
        id = '0;
        step();
        n_checks++; if (flush !== 1'b1 || rollback !== 32'h204 || oh !== 6'b000010 || res !== 1'b0) begin n_errors++; $display("FAIL bltu got %b %h %b %b exp 1 00000204 000010 0", flush, rollback, oh, res); end
        step();
    endtask

    task automatic test_jalr();
        int base;
        base = m_mcnt;
        id = mk_j(32'h1000, 32'h300, 32'd3, 1'b1);
        step();
        id = '0; rs1 = 32'h2000;
        step();
        n_checks++; if (flush !== 1'b1 || rollback !== 32'h2002 || btf !== 1'b0) begin n_errors++; $display("FAIL jalr got %b %h %b exp 1 00002002 0", flush, rollback, btf); end
        n_checks++; if (mcnt !== 32'(base + 1) || oh !== 6'b000010) begin n_errors++; $display("FAIL jalr_cnt got %0d %b exp %0d 000010", mcnt, oh, base + 1); end
        step();
    endtask

    task automatic test_back_to_back();
        int pulses, b0, m0;
        b0 = m_bcnt; m0 = m_mcnt; pulses = 0;
        rs1 = 32'd7; rs2 = 32'd7;
        id = mk_b(3'd0, 32'h400, 32'h8, 1'b0);
        step();
        id = mk_b(3'd0, 32'h404, 32'h8, 1'b0);
        step();
        if (flush === 1'b1) pulses++;
        id = '0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (flush === 1'b1) pulses++;
        end
        n_checks++; if (pulses != 1) begin n_errors++; $display("FAIL b2b_pulses got %0d exp 1", pulses); end
        n_checks++; if (bcnt !== 32'(b0 + 1) || mcnt !== 32'(m0 + 1)) begin n_errors++; $display("FAIL b2b_cnt got %0d/%0d exp %0d/%0d", bcnt, mcnt, b0 + 1, m0 + 1); end
    endtask

    task automatic test_stall_reset();
        id = mk_b(3'd1, 32'h500, 32'h20, 1'b0);
        step();
        id = '0; rs1 = 32'd1; rs2 = 32'd2; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (flush !== 1'b0) begin n_errors++; $display("FAIL stall_noflush cyc %0d got %b exp 0", i, flush); end
        end
        stall = 1'b0;
        step();
        n_checks++; if (flush !== 1'b1 || rollback !== 32'h520 || oh !== 6'b010000) begin n_errors++; $display("FAIL stall_release got %b %h %b exp 1 00000520 010000", flush, rollback, oh); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if ({flush, btf, res, oh} !== 9'd0 || rollback !== 32'd0 || pcf !== 32'd0) begin n_errors++; $display("FAIL midflush_reset got %b %h %h exp 0", {flush, btf, res, oh}, rollback, pcf); end
        n_checks++; if (bcnt !== 32'd0 || mcnt !== 32'd0) begin n_errors++; $display("FAIL midflush_cnt got %0d/%0d exp 0/0", bcnt, mcnt); end
        model_reset();
        id = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic [31:0] pool [4];
        pool[0] = 32'd0; pool[1] = 32'd1; pool[2] = 32'hFFFF_FFFF; pool[3] = 32'h8000_0000;
        for (int c = 0; c < 400; c++) begin
            case ($urandom_range(0, 3))
                0:       id = '0;
                1, 2:    id = mk_b(3'($urandom_range(0, 7)), $urandom & 32'hFFFF_FFFC, $urandom, 1'($urandom_range(0, 1)));
                default: id = mk_j(pool[$urandom_range(0, 3)], $urandom, $urandom, 1'($urandom_range(0, 1)));
            endcase
            rs1   = ($urandom_range(0, 3) == 0) ? $urandom : pool[$urandom_range(0, 3)];
            rs2   = ($urandom_range(0, 3) == 0) ? $urandom : pool[$urandom_range(0, 3)];
            stall = ($urandom_range(0, 4) == 0);
            step();
            n_checks++; if (flush !== m_flush || btf !== m_btf || res !== m_res) begin n_errors++; $display("FAIL rnd_strobes cyc %0d got %b%b%b exp %b%b%b", c, flush, btf, res, m_flush, m_btf, m_res); end
            n_checks++; if (rollback !== m_rb || pcf !== m_pcf || oh !== m_oh) begin n_errors++; $display("FAIL rnd_fields cyc %0d got %h %h %b exp %h %h %b", c, rollback, pcf, oh, m_rb, m_pcf, m_oh); end
            n_checks++; if (bcnt !== 32'(m_bcnt) || mcnt !== 32'(m_mcnt)) begin n_errors++; $display("FAIL rnd_cnt cyc %0d got %0d/%0d exp %0d/%0d", c, bcnt, mcnt, m_bcnt, m_mcnt); end
            n_checks++; if (bcnt4 !== 4'(sat4(m_bcnt)) || mcnt4 !== 4'(sat4(m_mcnt))) begin n_errors++; $display("FAIL rnd_cnt4 cyc %0d got %0d/%0d exp %0d/%0d", c, bcnt4, mcnt4, sat4(m_bcnt), sat4(m_mcnt)); end
        end
        stall = 1'b0;
    endtask

    task automatic test_saturate();
        rs1 = 32'd4;
        id  = mk_j(32'd0, 32'h600, 32'd0, 1'b1);
        for (int i = 0; i < 90; i++) step();
        id = '0;
        repeat (3) step();
        n_checks++; if (m_mcnt < 16 || mcnt4 !== 4'hF) begin n_errors++; $display("FAIL sat_mcnt4 got %h exp f (events %0d)", mcnt4, m_mcnt); end
        n_checks++; if (mcnt !== 32'(m_mcnt) || bcnt4 !== 4'(sat4(m_bcnt))) begin n_errors++; $display("FAIL sat_wide got %0d %0d exp %0d %0d", mcnt, bcnt4, m_mcnt, sat4(m_bcnt)); end
    endtask

    initial begin
        id = '0;
        model_reset();
        test_reset();
        test_beq();
        test_blt_bltu();
        test_jalr();
        test_back_to_back();
        test_stall_reset();
        test_random();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
